seq_multiplier: RTL and testbench
=================================

# seq_multiplier

Parametrised, iterative shift-add multiplier with a selectable signed/unsigned mode and full valid/ready handshaking on both the operand and result sides. It replaces the fixed 8-bit unsigned multiplier: same role in the datapath, but with generic operand width, two's-complement support and result backpressure. It sits between an operand producer and a result consumer, one multiplication in flight at a time.

## Interface
- WIDTH, 8: operand width in bits, at least 2; the result is 2*WIDTH bits.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- in_a  in  WIDTH  multiplicand.
- in_b  in  WIDTH  multiplier.
- in_signed  in  1  1: operands and result are two's complement; 0: unsigned.
- in_vld  in  1  operands valid.
- in_rdy  out  1  block can accept operands.
- res  out  2*WIDTH  product.
- res_vld  out  1  res holds a completed product.
- res_ack  in  1  consumer takes res.

## Operation
- The FSM has three states: IDLE, BUSY and DONE.
- in_rdy = (state == IDLE). res_vld = (state == DONE).
- **IDLE**
  - in_vld && in_rdy at an edge is the accept edge. On it the block:
    - registers the magnitudes |in_a| and |in_b| (only when in_signed = 1);
    - registers the result sign neg = in_signed & (a_msb ^ b_msb);
    - clears the accumulator and the iteration counter;
    - moves to BUSY.
- **BUSY**
  - Each edge performs one radix-2 step: if the multiplier LSB = 1, add the shifted multiplicand to the accumulator; shift both.
  - The counter runs 0..WIDTH-1.
  - On the edge completing step WIDTH-1:
    - res <= neg ? -acc_next : acc_next, taken mod 2^(2*WIDTH);
    - state moves to DONE.
- **DONE**
  - res is held stable.
  - res_vld && res_ack at an edge moves to IDLE.
- Latency is fixed. There is no early termination on zero operands.
- Width and arithmetic:
  - Magnitudes fit in WIDTH unsigned bits, including the most negative value (-2^(WIDTH-1)).
  - The unsigned accumulator is 2*WIDTH bits and cannot overflow.
  - The signed product always fits in 2*WIDTH bits.
- Inputs are ignored outside IDLE:
  - in_vld in BUSY or DONE has no effect;
  - in_a, in_b and in_signed may change freely after the accept edge;
  - res_ack outside DONE has no effect.
- Reset (rst_n = 0 at an edge) takes priority over everything:
  - state goes to IDLE, accumulator, counter and res go to 0, neg goes to 0;
  - an in-flight operation is discarded and no result is produced.

## Timing
- Values after reset: in_rdy = 1, res_vld = 0, res = 0.
- Accept at edge E:
  - in_rdy = 0 from edge E onward;
  - res_vld = 1 after edge E+WIDTH, i.e. WIDTH cycles after accept.
- res_vld stays high and res stays unchanged until the ack edge.
- The ack edge D (res_vld && res_ack) has these effects:
  - after D: res_vld = 0 and in_rdy = 1;
  - res keeps its last value until the next completion.
- Earliest next accept is edge D+1. With res_ack tied high and in_vld held high, accepts come every WIDTH+2 cycles (10 for WIDTH = 8).
- There is no combinational path from any input to any output. in_rdy, res_vld and res are all register-derived.

## Structure
- Package seq_multiplier_pkg holds:
  - the state typedef, an enum of IDLE, BUSY and DONE;
  - a function computing the counter width, $clog2(WIDTH).
- No sub-module: the FSM and the datapath (magnitude conversion, accumulator, shift registers, counter, sign fix) stay in one module of roughly 150–250 lines.

## Test plan
All values below are for WIDTH = 8.
- **Reset values:** hold rst_n low for 2 cycles, then release -> in_rdy = 1, res_vld = 0, res = 0x0000.
- **Unsigned products:** with in_signed = 0:
  - 13 * 11 -> res = 0x008F, with res_vld rising exactly 8 cycles after the accept edge;
  - 255 * 255 -> 0xFE01;
  - 0 * 200 -> 0x0000.
- **Signed products:** with in_signed = 1:
  - 0xFD * 0x05 (-3*5) -> 0xFFF1;
  - 0x80 * 0x80 (-128*-128) -> 0x4000;
  - 0x80 * 0x7F -> 0xC080;
  - 0xFF * 0xFF -> 0x0001.
  - The same bit pattern 0xFD * 0x05 with in_signed = 0 -> 0x04F1.
- **Backpressure:** after completion, hold res_ack = 0 for 5 cycles while driving in_vld = 1 with new operands. Require:
  - res_vld stays 1, res is unchanged, in_rdy = 0;
  - no operand is accepted;
  - after res_ack = 1, in_rdy = 1 the next cycle.
- **Reset mid-operation:** assert rst_n = 0 during the 4th BUSY cycle. Require:
  - after that edge: in_rdy = 1, res = 0x0000;
  - res_vld stays 0 through the next 10 cycles while in_vld = 0.
- **Streaming:** in_vld and res_ack tied high with 20 random operand pairs in mixed modes. Require:
  - a self-checking model matches every product;
  - exactly one result per 10 cycles.

Source files
------------

// File: rtl/seq_multiplier_pkg.sv
// Shared types and helpers for the iterative shift-add multiplier.
package seq_multiplier_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // Counter must hold 0..width-1.
  function automatic int cnt_w(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/seq_multiplier.sv
// Radix-2 shift-add multiplier, one product per WIDTH+2 cycles, signed or unsigned,
// with valid/ready on operands and valid/ack on the result.
module seq_multiplier
  import seq_multiplier_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_signed,
  input  logic               in_vld,
  output logic               in_rdy,
  output logic [2*WIDTH-1:0] res,
  output logic               res_vld,
  input  logic               res_ack
);

  localparam int CW = cnt_w(WIDTH);
  localparam int PW = 2 * WIDTH;

  state_e           state_q, state_d;
  logic [PW-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [PW-1:0]    acc_next;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             neg_q, neg_d;
  logic [PW-1:0]    res_q, res_d;
  logic             in_rdy_q, in_rdy_d;
  logic             res_vld_q, res_vld_d;

  // Magnitude fits in WIDTH unsigned bits, including -2^(WIDTH-1).
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic is_signed);
    return (is_signed && v[WIDTH-1]) ? (~v + WIDTH'(1)) : v;
  endfunction

  function automatic logic [PW-1:0] apply_sign(input logic [PW-1:0] v,
                                               input logic neg);
    return neg ? (~v + PW'(1)) : v;
  endfunction

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    res_d    = res_q;
    acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);

    unique case (state_q)
      IDLE: begin
        if (in_vld) begin
          mcand_d  = {{WIDTH{1'b0}}, magnitude(in_a, in_signed)};
          mplier_d = magnitude(in_b, in_signed);
          neg_d    = in_signed & (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        acc_d    = acc_next;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          res_d   = apply_sign(acc_next, neg_q);
          state_d = DONE;
        end
      end
      DONE: begin
        if (res_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Handshake outputs are registered decodes of the next state.
    in_rdy_d  = (state_d == IDLE);
    res_vld_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      res_q     <= '0;
      in_rdy_q  <= 1'b1;
      res_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
      res_q     <= res_d;
      in_rdy_q  <= in_rdy_d;
      res_vld_q <= res_vld_d;
    end
  end

  assign in_rdy  = in_rdy_q;
  assign res_vld = res_vld_q;
  assign res     = res_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier (WIDTH = 8): vector table plus scoreboard.
module tb_seq_multiplier;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [W-1:0]   in_a, in_b;
  logic           in_signed, in_vld, res_ack;
  logic           in_rdy, res_vld;
  logic [2*W-1:0] res;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  int last_ack = -1;
  int n_acc = 0;
  bit streaming = 1'b0;
  logic [2*W-1:0] exp_q[$];

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           s;
    logic [2*W-1:0] exp;
  } vec_t;

  vec_t vecs[8];

  seq_multiplier #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_a(in_a), .in_b(in_b), .in_signed(in_signed),
    .in_vld(in_vld), .in_rdy(in_rdy), .res(res), .res_vld(res_vld), .res_ack(res_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic s);
    int sa, sb, p;
    sa = s ? int'($signed(a)) : int'(a);
    sb = s ? int'($signed(b)) : int'(b);
    p  = sa * sb;
    return p[2*W-1:0];
  endfunction

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (rst_n && in_vld && in_rdy) begin
      exp_q.push_back(model(in_a, in_b, in_signed));
      n_acc++;
    end
    if (rst_n && res_vld && res_ack) begin
      if (exp_q.size() == 0) check("sb_unexpected_result", 32'(res), 32'hDEAD);
      else check("sb_res", 32'(res), 32'(exp_q.pop_front()));
      if (streaming && last_ack >= 0) check("stream_period", 32'(cyc - last_ack), 32'd10);
      last_ack = cyc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input vec_t v, input string name);
    int lat;
    check({name, "_rdy_before"}, 32'(in_rdy), 32'd1);
    in_a = v.a; in_b = v.b; in_signed = v.s; in_vld = 1'b1; res_ack = 1'b0;
    tick();
    in_vld = 1'b0;
    in_a = ~v.a; in_b = ~v.b; in_signed = ~v.s;
    lat = 0;
    while (!res_vld && lat < 20) begin
      tick();
      lat++;
    end
    check({name, "_latency"}, 32'(lat), 32'd8);
    check({name, "_res"}, 32'(res), 32'(v.exp));
    res_ack = 1'b1;
    tick();
    res_ack = 1'b0;
    check({name, "_vld_after_ack"}, 32'(res_vld), 32'd0);
    check({name, "_rdy_after_ack"}, 32'(in_rdy), 32'd1);
    check({name, "_res_held"}, 32'(res), 32'(v.exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic [2*W-1:0] held;
    int guard;

    vecs[0] = '{a: 8'd13,  b: 8'd11,  s: 1'b0, exp: 16'h008F};
    vecs[1] = '{a: 8'd255, b: 8'd255, s: 1'b0, exp: 16'hFE01};
    vecs[2] = '{a: 8'd0,   b: 8'd200, s: 1'b0, exp: 16'h0000};
    vecs[3] = '{a: 8'hFD,  b: 8'h05,  s: 1'b1, exp: 16'hFFF1};
    vecs[4] = '{a: 8'h80,  b: 8'h80,  s: 1'b1, exp: 16'h4000};
    vecs[5] = '{a: 8'h80,  b: 8'h7F,  s: 1'b1, exp: 16'hC080};
    vecs[6] = '{a: 8'hFF,  b: 8'hFF,  s: 1'b1, exp: 16'h0001};
    vecs[7] = '{a: 8'hFD,  b: 8'h05,  s: 1'b0, exp: 16'h04F1};

    rst_n = 1'b0; in_a = '0; in_b = '0; in_signed = 1'b0; in_vld = 1'b0; res_ack = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    check("reset_in_rdy", 32'(in_rdy), 32'd1);
    check("reset_res_vld", 32'(res_vld), 32'd0);
    check("reset_res", 32'(res), 32'd0);

    for (int i = 0; i < 8; i++) run_op(vecs[i], $sformatf("vec%0d", i));

    // Backpressure: result held while new operands are offered.
    in_a = 8'd7; in_b = 8'd9; in_signed = 1'b0; in_vld = 1'b1;
    tick();
    in_vld = 1'b0;
    guard = 0;
    while (!res_vld && guard < 20) begin tick(); guard++; end
    check("bp_completed", 32'(res_vld), 32'd1);
    held = res;
    check("bp_res", 32'(held), 32'd63);
    in_a = 8'd100; in_b = 8'd3; in_signed = 1'b1; in_vld = 1'b1; res_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_vld_hold", 32'(res_vld), 32'd1);
      check("bp_res_hold", 32'(res), 32'(held));
      check("bp_rdy_low", 32'(in_rdy), 32'd0);
    end
    res_ack = 1'b1; in_vld = 1'b0;
    tick();
    res_ack = 1'b0;
    check("bp_rdy_after_ack", 32'(in_rdy), 32'd1);
    check("bp_vld_after_ack", 32'(res_vld), 32'd0);
    check("bp_no_accept", 32'(exp_q.size()), 32'd0);

    // Reset during the 4th BUSY cycle.
    in_a = 8'd21; in_b = 8'd5; in_signed = 1'b0; in_vld = 1'b1;
    tick();
    in_vld = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    exp_q.delete();
    check("rst_mid_in_rdy", 32'(in_rdy), 32'd1);
    check("rst_mid_res", 32'(res), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("rst_mid_no_vld", 32'(res_vld), 32'd0);
    end

    // Streaming in mixed modes.
    last_ack = -1;
    streaming = 1'b1;
    n_acc = 0;
    res_ack = 1'b1;
    in_vld = 1'b1;
    guard = 0;
    while (n_acc < 20 && guard < 400) begin
      in_a = W'($urandom);
      in_b = W'($urandom);
      in_signed = 1'($urandom_range(0, 1));
      tick();
      guard++;
    end
    in_vld = 1'b0;
    check("stream_accepts", 32'(n_acc), 32'd20);
    guard = 0;
    while (exp_q.size() != 0 && guard < 40) begin tick(); guard++; end
    check("stream_drained", 32'(exp_q.size()), 32'd0);
    streaming = 1'b0;
    res_ack = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
